debug_cmd_frontend: RTL and testbench

- Byte-stream command decoder sitting directly upstream of the debug harness.
- Accepts framed host bytes over a valid/ready link and drives the harness inputs: `debug_cmd`, `program_rom_mode`, `code_rom_addr_in`, `code_rom_data_in`, `reset_code_rom_n`.
- Watches `command_complete` and `exit_signal` and returns one status byte per frame.

---
 rtl/debug_pkg.sv | 38 +++
 rtl/dbg_timeout_ctr.sv | 32 +++
 rtl/debug_cmd_frontend.sv | 183 ++++++++++++++++++
 tb/tb_debug_cmd_frontend.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_pkg.sv
// Shared definitions for the debug command front end: host opcodes, status bytes,
// FSM state encoding and harness command encodings.
// Latency: n/a (definitions only). Backpressure: n/a.
package debug_pkg;

    // Host opcodes (first byte of a frame)
    localparam logic [7:0] OP_RUN   = 8'h01;
    localparam logic [7:0] OP_STEPI = 8'h02;
    localparam logic [7:0] OP_STEPC = 8'h03;
    localparam logic [7:0] OP_LOAD  = 8'h10;
    localparam logic [7:0] OP_CLEAR = 8'h20;

    // Status bytes returned to the host, one per frame
    localparam logic [7:0] ST_CMD_BASE = 8'hA0;  // OR'd with the harness command
    localparam logic [7:0] ST_LOAD_OK  = 8'hA4;
    localparam logic [7:0] ST_CLEAR_OK = 8'hA5;
    localparam logic [7:0] ST_EXIT     = 8'hE0;
    localparam logic [7:0] ST_TIMEOUT  = 8'hED;
    localparam logic [7:0] ST_RANGE    = 8'hEE;
    localparam logic [7:0] ST_BAD_OP   = 8'hEF;

    // Harness command encodings on debug_cmd
    localparam logic [3:0] CMD_IDLE  = 4'd0;
    localparam logic [3:0] CMD_RUN   = 4'd1;
    localparam logic [3:0] CMD_STEPI = 4'd2;
    localparam logic [3:0] CMD_STEPC = 4'd3;

    typedef enum logic [3:0] {
        S_IDLE, S_ISSUE, S_WAIT, S_HDR_AH, S_HDR_AL, S_HDR_LEN,
        S_DATA, S_WR, S_DRAIN, S_CLR, S_RESP
    } state_t;

    // Length byte of a LOAD header; zero encodes a full 256-byte frame
    function automatic logic [8:0] frame_len(input logic [7:0] len_byte);
        return (len_byte == 8'h00) ? 9'd256 : {1'b0, len_byte};
    endfunction

endpackage

// File: rtl/dbg_timeout_ctr.sv
// Inter-byte idle counter: counts enabled cycles since the last reload, flags expiry.
// Latency: expired is combinational from the count; fires on the TIMEOUT_CYCLES-th idle cycle.
// Backpressure: none; reload wins over expiry in the same cycle.
// Ports: clk, reset (async, active-high), reload (byte accepted), enable (counting states), expired.
module dbg_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic clk,
    input  logic reset,
    input  logic reload,
    input  logic enable,
    output logic expired
);

    localparam int            CW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (reload) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expired = enable && !reload && (cnt == LAST);

endmodule

// File: rtl/debug_cmd_frontend.sv
// Framed host-byte decoder driving the debug harness; one status byte back per frame.
// Latency: registered outputs, command/strobe in the cycle after the accepting edge.
// Backpressure: rx_ready dropped outside IDLE/HDR/DATA/DRAIN; tx_valid held until tx_ready.
// Ports: clk, reset; rx_valid/rx_data/rx_ready host in; tx_valid/tx_data/tx_ready status out;
//        debug_cmd, program_rom_mode, code_rom_addr_in, code_rom_data_in, reset_code_rom_n to
//        the harness; command_complete, exit_signal from the harness.
module debug_cmd_frontend
    import debug_pkg::*;
#(
    parameter int MEM_BYTES      = 44,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic [3:0]  debug_cmd,
    output logic        program_rom_mode,
    output logic [11:0] code_rom_addr_in,
    output logic [7:0]  code_rom_data_in,
    output logic        reset_code_rom_n,
    input  logic        command_complete,
    input  logic        exit_signal
);

    state_t      state, state_d;
    logic [7:0]  status_d;
    logic [3:0]  cmd_q, cmd_d;
    logic [11:0] addr_q;
    logic [8:0]  len_q;        // bytes still expected in DATA/DRAIN
    logic        clr_phase_q;  // second cycle of the ROM clear
    logic        accept, tmo, tmo_en;
    logic [12:0] load_end;

    logic       rx_ready_d, tx_valid_d, program_rom_mode_d, reset_code_rom_n_d;
    logic [3:0] debug_cmd_d;

    assign accept   = rx_valid && rx_ready;
    assign tmo_en   = state inside {S_HDR_AH, S_HDR_AL, S_HDR_LEN, S_DATA, S_DRAIN};
    // 13-bit sum so a frame running past 4095 is rejected instead of wrapping
    assign load_end = {1'b0, addr_q} + {4'b0000, frame_len(rx_data)};

    dbg_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .reload  (accept),
        .enable  (tmo_en),
        .expired (tmo)
    );

    // State register plus output registers (outputs are decoded from the next state)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= S_IDLE;
            rx_ready         <= 1'b0;
            tx_valid         <= 1'b0;
            tx_data          <= 8'h00;
            debug_cmd        <= CMD_IDLE;
            program_rom_mode <= 1'b0;
            reset_code_rom_n <= 1'b1;
        end else begin
            state            <= state_d;
            rx_ready         <= rx_ready_d;
            tx_valid         <= tx_valid_d;
            tx_data          <= status_d;
            debug_cmd        <= debug_cmd_d;
            program_rom_mode <= program_rom_mode_d;
            reset_code_rom_n <= reset_code_rom_n_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state;
        status_d = tx_data;
        cmd_d    = cmd_q;
        case (state)
            S_IDLE: if (accept) begin
                cmd_d = rx_data[3:0];
                case (rx_data)
                    OP_RUN, OP_STEPI, OP_STEPC: state_d = S_ISSUE;
                    OP_LOAD:                    state_d = S_HDR_AH;
                    OP_CLEAR:                   state_d = S_CLR;
                    default: begin
                        state_d  = S_RESP;
                        status_d = ST_BAD_OP;
                    end
                endcase
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                // exit outranks completion when both arrive together
                if (exit_signal) begin
                    state_d  = S_RESP;
                    status_d = ST_EXIT;
                end else if (command_complete) begin
                    state_d  = S_RESP;
                    status_d = ST_CMD_BASE | {4'h0, cmd_q};
                end
            end
            S_HDR_AH, S_HDR_AL, S_HDR_LEN, S_DATA, S_DRAIN: begin
                if (tmo) begin
                    state_d  = S_RESP;
                    status_d = ST_TIMEOUT;
                end else if (accept) begin
                    case (state)
                        S_HDR_AH:  state_d = S_HDR_AL;
                        S_HDR_AL:  state_d = S_HDR_LEN;
                        S_HDR_LEN: state_d = (load_end > 13'(MEM_BYTES)) ? S_DRAIN : S_DATA;
                        S_DATA:    state_d = S_WR;
                        default: begin
                            if (len_q == 9'd1) begin
                                state_d  = S_RESP;
                                status_d = ST_RANGE;
                            end
                        end
                    endcase
                end
            end
            S_WR: begin
                if (len_q == 9'd1) begin
                    state_d  = S_RESP;
                    status_d = ST_LOAD_OK;
                end else begin
                    state_d = S_DATA;
                end
            end
            S_CLR: begin
                if (clr_phase_q) begin
                    state_d  = S_RESP;
                    status_d = ST_CLEAR_OK;
                end
            end
            S_RESP: if (tx_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from the next state, registered above
    always_comb begin
        rx_ready_d         = state_d inside {S_IDLE, S_HDR_AH, S_HDR_AL, S_HDR_LEN, S_DATA, S_DRAIN};
        tx_valid_d         = (state_d == S_RESP);
        debug_cmd_d        = (state_d == S_ISSUE) ? cmd_d : CMD_IDLE;
        program_rom_mode_d = (state_d == S_WR);
        reset_code_rom_n_d = (state_d != S_CLR);
    end

    // Frame datapath: address, remaining length, ROM write registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_q            <= CMD_IDLE;
            addr_q           <= '0;
            len_q            <= '0;
            clr_phase_q      <= 1'b0;
            code_rom_addr_in <= '0;
            code_rom_data_in <= '0;
        end else begin
            cmd_q       <= cmd_d;
            clr_phase_q <= (state == S_CLR) && !clr_phase_q;
            case (state)
                S_HDR_AH:  if (accept) addr_q <= {rx_data[3:0], 8'h00};
                S_HDR_AL:  if (accept) addr_q[7:0] <= rx_data;
                S_HDR_LEN: if (accept) len_q <= frame_len(rx_data);
                S_DATA: if (accept) begin
                    code_rom_addr_in <= addr_q;
                    code_rom_data_in <= rx_data;
                end
                // address moves on only after the write edge, so the harness sees a stable pair
                S_WR: begin
                    addr_q <= addr_q + 12'd1;
                    len_q  <= len_q - 9'd1;
                end
                S_DRAIN: if (accept) len_q <= len_q - 9'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_debug_cmd_frontend.sv
module tb_debug_cmd_frontend;

    localparam int MEM = 44;

    logic        clk = 1'b0, reset = 1'b1;
    logic        rx_valid = 1'b0, tx_ready = 1'b0;
    logic        command_complete = 1'b0, exit_signal = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready, tx_valid, program_rom_mode, reset_code_rom_n;
    logic [7:0]  tx_data, code_rom_data_in;
    logic [3:0]  debug_cmd;
    logic [11:0] code_rom_addr_in;

    debug_cmd_frontend #(.MEM_BYTES(MEM), .TIMEOUT_CYCLES(4096)) dut (
        .clk              (clk),
        .reset            (reset),
        .rx_valid         (rx_valid),
        .rx_data          (rx_data),
        .rx_ready         (rx_ready),
        .tx_valid         (tx_valid),
        .tx_data          (tx_data),
        .tx_ready         (tx_ready),
        .debug_cmd        (debug_cmd),
        .program_rom_mode (program_rom_mode),
        .code_rom_addr_in (code_rom_addr_in),
        .code_rom_data_in (code_rom_data_in),
        .reset_code_rom_n (reset_code_rom_n),
        .command_complete (command_complete),
        .exit_signal      (exit_signal)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    int n_writes = 0, n_cmd_cycles = 0;
    logic [11:0] exp_wr_addr[$];
    logic [7:0]  exp_wr_data[$];
    logic [7:0]  exp_status = 8'h00;
    logic [3:0]  exp_cmd = 4'h0;
    logic [7:0]  payload[256];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model of a LOAD frame's outcome from the frame rules
    function automatic logic [7:0] load_status(int addr, int lenb, int nsent);
        int len = (lenb == 0) ? 256 : lenb;
        if (addr + len > MEM) return 8'hEE;
        if (nsent < len)      return 8'hED;
        return 8'hA4;
    endfunction

    // Compare process: every cycle, against the model's expectations
    logic       prev_v = 1'b0, prev_r = 1'b0;
    logic [7:0] prev_d = 8'h00;
    always @(negedge clk) begin
        if (reset) begin
            prev_v = 1'b0;
        end else begin
            if (program_rom_mode) begin
                n_writes++;
                check("wr_expected", exp_wr_addr.size() > 0, 1);
                check("strobe_excl", debug_cmd, 0);
                if (exp_wr_addr.size() > 0) begin
                    check("wr_addr", code_rom_addr_in, exp_wr_addr.pop_front());
                    check("wr_data", code_rom_data_in, exp_wr_data.pop_front());
                end
            end
            if (debug_cmd != 4'h0) begin
                n_cmd_cycles++;
                check("cmd_code", debug_cmd, exp_cmd);
            end
            if (tx_valid) check("status_byte", tx_data, exp_status);
            if (prev_v && !prev_r) check("tx_hold", {tx_valid, tx_data}, {1'b1, prev_d});
            prev_v = tx_valid;
            prev_r = tx_ready;
            prev_d = tx_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns one time unit after the accepting edge
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) begin
            check("rx_accept", rx_ready, 1);
            rx_valid = 1'b0;
        end else begin
            tick();
            rx_valid = 1'b0;
        end
    endtask

    task automatic get_status(input logic [7:0] lit, input int hold, input int bound,
                              output int waited);
        int n = 0;
        while (!tx_valid && n < bound) begin
            tick();
            n++;
        end
        waited = n;
        check("resp_valid", tx_valid, 1);
        check("resp_literal", tx_data, lit);
        for (int i = 0; i < hold; i++) begin
            check("resp_held", {tx_valid, tx_data}, {1'b1, lit});
            tick();
        end
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        check("resp_release", tx_valid, 0);
    endtask

    task automatic run_load(input int addr, input int lenb, input int nsend);
        int len = (lenb == 0) ? 256 : lenb;
        exp_status = load_status(addr, lenb, nsend);
        if (addr + len <= MEM)
            for (int i = 0; i < nsend; i++) begin
                exp_wr_addr.push_back(12'(addr + i));
                exp_wr_data.push_back(payload[i]);
            end
        send_byte(8'h10);
        send_byte(8'(addr >> 8));
        send_byte(8'(addr));
        send_byte(8'(lenb));
        for (int i = 0; i < nsend; i++) send_byte(payload[i]);
    endtask

    task automatic issue(input logic [7:0] op, input logic cc, input logic ex, input int hold);
        int w;
        exp_cmd    = op[3:0];
        exp_status = ex ? 8'hE0 : (8'hA0 | {4'h0, op[3:0]});
        send_byte(op);
        check("cmd_at_n1", debug_cmd, {28'h0, op[3:0]});
        for (int i = 0; i < 20; i++) begin
            check("rx_ready_wait", rx_ready, 0);
            tick();
        end
        command_complete = cc;
        exit_signal      = ex;
        tick();
        command_complete = 1'b0;
        exit_signal      = 1'b0;
        check("status_at_m1", tx_valid, 1);
        get_status(ex ? 8'hE0 : {4'hA, op[3:0]}, hold, 10, w);
    endtask

    initial begin
        int w, base;

        // Reset values
        repeat (3) tick();
        check("rst_rx_ready", rx_ready, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_debug_cmd", debug_cmd, 0);
        check("rst_prog_mode", program_rom_mode, 0);
        check("rst_addr", code_rom_addr_in, 0);
        check("rst_data", code_rom_data_in, 0);
        check("rst_rom_n", reset_code_rom_n, 1);
        reset = 1'b0;
        tick();
        check("idle_rx_ready", rx_ready, 1);

        // RUN, completion after 20 cycles
        issue(8'h01, 1'b1, 1'b0, 0);
        // STEPI with simultaneous complete/exit, host stalls 5 cycles
        issue(8'h02, 1'b1, 1'b1, 5);
        // STEPC completion, then RUN ended by exit alone
        issue(8'h03, 1'b1, 1'b0, 1);
        issue(8'h01, 1'b0, 1'b1, 0);
        check("cmd_pulse_cycles", n_cmd_cycles, 4);

        // Unknown opcode: status the cycle after acceptance
        exp_status = 8'hEF;
        send_byte(8'h55);
        check("badop_valid_n1", tx_valid, 1);
        get_status(8'hEF, 0, 2, w);

        // LOAD in range
        payload[0] = 8'hDE; payload[1] = 8'hAD; payload[2] = 8'hBE; payload[3] = 8'hEF;
        base = n_writes;
        exp_status = load_status(8, 4, 1);
        exp_wr_addr.push_back(12'd8);  exp_wr_data.push_back(8'hDE);
        send_byte(8'h10); send_byte(8'h00); send_byte(8'h08); send_byte(8'h04);
        send_byte(8'hDE);
        check("wr_strobe_n1", program_rom_mode, 1);
        check("wr_addr_n1", code_rom_addr_in, 12'd8);
        tick();
        check("wr_strobe_1cyc", program_rom_mode, 0);
        exp_status = load_status(8, 4, 4);
        for (int i = 1; i < 4; i++) begin
            exp_wr_addr.push_back(12'(8 + i));
            exp_wr_data.push_back(payload[i]);
            send_byte(payload[i]);
        end
        get_status(8'hA4, 0, 10, w);
        check("ld_write_count", n_writes - base, 4);

        // LOAD ending exactly at the top of the ROM
        base = n_writes;
        run_load(40, 4, 4);
        get_status(8'hA4, 0, 10, w);
        check("ld_edge_writes", n_writes - base, 4);

        // LOAD out of range (42 + 4 > 44): bytes drained, nothing written
        base = n_writes;
        run_load(42, 4, 4);
        get_status(8'hEE, 0, 10, w);
        check("ld_oor_writes", n_writes - base, 0);

        // Length byte 0 is 256 bytes: out of range, all 256 drained
        for (int i = 0; i < 256; i++) payload[i] = 8'(i * 7);
        base = n_writes;
        run_load(0, 0, 256);
        get_status(8'hEE, 0, 10, w);
        check("ld_len0_writes", n_writes - base, 0);

        // LOAD timeout after one data byte
        payload[0] = 8'h5A;
        base = n_writes;
        run_load(20, 4, 1);
        get_status(8'hED, 0, 6000, w);
        check("tmo_not_early", w >= 4000, 1);
        check("tmo_writes", n_writes - base, 1);
        check("tmo_back_idle", rx_ready, 1);
        check("wr_queue_drained", exp_wr_addr.size(), 0);

        // Reset in the middle of a LOAD
        payload[0] = 8'h11; payload[1] = 8'h22;
        base = n_writes;
        run_load(0, 4, 2);
        tick();
        reset = 1'b1;
        #1;
        check("mid_rst_rx_ready", rx_ready, 0);
        check("mid_rst_prog_mode", program_rom_mode, 0);
        check("mid_rst_addr", code_rom_addr_in, 0);
        check("mid_rst_data", code_rom_data_in, 0);
        check("mid_rst_rom_n", reset_code_rom_n, 1);
        check("mid_rst_tx_valid", tx_valid, 0);
        check("mid_rst_writes", n_writes - base, 2);
        exp_wr_addr.delete();
        exp_wr_data.delete();
        tick();
        reset = 1'b0;
        tick();

        // CLEAR: two cycles of reset_code_rom_n low, status from N+3
        exp_status = 8'hA5;
        send_byte(8'h20);
        check("clr_low_n1", reset_code_rom_n, 0);
        tick();
        check("clr_low_n2", reset_code_rom_n, 0);
        tick();
        check("clr_high_n3", reset_code_rom_n, 1);
        check("clr_valid_n3", tx_valid, 1);
        get_status(8'hA5, 0, 2, w);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
